// File: rtl/add_sub_seq_ctrl_if.sv
// add_sub_seq_ctrl_if: operand/result handshake bundle for the nibble-serial add/sub controller
interface add_sub_seq_ctrl_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             busy;
    modport master (output in_valid, m, a, b, out_ready,
                    input  in_ready, out_valid, sum, co, ovf, busy);
    modport slave  (input  in_valid, m, a, b, out_ready,
                    output in_ready, out_valid, sum, co, ovf, busy);
endinterface

// File: rtl/add_sub_seq_ctrl.sv
// add_sub_seq_ctrl: WIDTH-bit add/subtract computed one nibble per cycle, LSB nibble first,
// with valid/ready handshakes on operands and result.
module add_sub_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    add_sub_seq_ctrl_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = $clog2(N);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             m_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             co_r;
    logic             ovf_r;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_sum;
    logic [3:0]       low3_sum;
    logic             last;
    always_comb begin
        a_nib    = a_r[{idx, 2'b00} +: 4];
        b_nib    = b_r[{idx, 2'b00} +: 4] ^ {4{m_r}};
        nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
        // carry out of bit 2 is the carry into the MSB when this is the top nibble
        low3_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry};
        last     = idx == IW'(N - 1);
    end
    assign bus.in_ready  = state == IDLE && !rst;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.sum       = sum_r;
    assign bus.co        = co_r;
    assign bus.ovf       = ovf_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            m_r   <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            co_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.in_valid) begin
                state <= RUN;
                a_r   <= bus.a;
                b_r   <= bus.b;
                m_r   <= bus.m;
                carry <= bus.m;
                idx   <= '0;
                sum_r <= '0;
            end
        end else if (state == RUN) begin
            sum_r[{idx, 2'b00} +: 4] <= nib_sum[3:0];
            carry <= nib_sum[4];
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                state <= DONE;
                co_r  <= nib_sum[4];
                ovf_r <= nib_sum[4] ^ low3_sum[3];
            end
        end else begin
            state <= bus.out_ready ? IDLE : DONE;
        end
    end
endmodule

// File: doc/add_sub_seq_ctrl.md
Name: add_sub_seq_ctrl

Overview:
Sequencing controller that performs WIDTH-bit add/subtract by reusing one 4-bit add/sub slice over successive cycles (nibble-serial, LSB nibble first), chaining carry between nibbles.
Sits in front of the arithmetic datapath so wide operands can be processed on the existing 4-bit hardware width.
Uses a valid/ready handshake on input and on output.
Produces sum, unsigned carry/borrow and signed overflow.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands a, b, m are valid
in_ready  output  1  controller can accept operands; high only in IDLE and when rst is low
m  input  1  mode: 0 = add (a+b), 1 = subtract (a-b)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
co  output  1  final carry out; in subtract mode, 1 = no borrow (a >= b unsigned)
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- States and transitions:
  - IDLE -> RUN on in_valid && in_ready.
  - RUN -> DONE after N = WIDTH/4 nibble cycles.
  - DONE -> IDLE on out_ready.
- Reset (rst=1 at an edge):
  - state=IDLE; sum=0, co=0, ovf=0, out_valid=0, busy=0; internal nibble index, carry and operand registers cleared.
  - in_ready=0 while rst is high, 1 in the first cycle after rst is released.
- Acceptance edge:
  - Latch a, b, m.
  - Carry register = m (two's-complement +1 for subtract).
  - Nibble index = 0; sum register cleared.
  - Input changes after acceptance have no effect on the running operation.
- RUN, nibble k (k = 0..N-1), one per clock:
  - b_eff = b[4k+3:4k] XOR {4{m}}.
  - {c, s} = a[4k+3:4k] + b_eff + carry; sum[4k+3:4k] <= s; carry <= c.
  - On k = N-1, record carry into bit WIDTH-1 for overflow.
- Latency:
  - Acceptance edge E0; nibbles written at E1..EN.
  - At EN: state -> DONE, out_valid=1, co = final carry, ovf = carry_into_MSB XOR co.
  - out_valid therefore first observable N cycles after the acceptance edge (4 cycles for WIDTH=16).
- DONE:
  - sum, co, ovf, out_valid held stable while out_ready=0 (any length of backpressure).
  - On the edge with out_valid && out_ready: out_valid=0, state=IDLE.
  - sum, co, ovf keep their values until the next acceptance clears sum.
  - in_ready rises the cycle after output acceptance; no same-cycle output/input overlap.
- in_valid while not in IDLE is ignored; the operand is not captured and is not queued.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid for the aborted operation; all outputs take reset values at that edge.
- Wrap-around: results are taken modulo 2^WIDTH; overflow is reported only through co/ovf, never by extending sum.
- Purely synchronous; no combinational path from a/b to sum. in_ready depends on state and rst only.

Test Plan:
1. WIDTH=16, m=0, a=0x1234, b=0x0FCD -> sum=0x2201, co=0, ovf=0; out_valid exactly 4 cycles after the acceptance edge; busy high throughout.
2. m=1, a=0x1000, b=0x0001 -> sum=0x0FFF, co=1, ovf=0. m=1, a=0x0001, b=0x0005 -> sum=0xFFFC, co=0, ovf=0.
3. Boundaries:
   - m=0, a=0x7FFF, b=0x0001 -> sum=0x8000, co=0, ovf=1.
   - m=0, a=0xFFFF, b=0x0001 -> sum=0x0000, co=1, ovf=0.
   - m=1, a=0x8000, b=0x0001 -> sum=0x7FFF, co=1, ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid -> sum/co/ovf/out_valid stable, in_ready=0; after out_ready=1 for one edge -> out_valid=0, then in_ready=1 the following cycle.
5. Ignored input: during RUN, change a/b to 0xFFFF and pulse in_valid -> first result unaffected (test 1 values); no second result is produced.
6. Reset mid-operation: assert rst for one edge after nibble 2 of test 1 -> out_valid=0, sum=0, busy=0 on that edge; in_ready=1 the next cycle; a following operation with a=0x0003, b=0x0004, m=0 gives sum=0x0007.
